// File: rtl/demux_router_4.sv
// Four-way word router: each channel buffers up to two words in its own FIFO
// and keeps a saturating count of delivered words.
module demux_router_4 #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [1:0]         in_sel,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [4*WIDTH-1:0] out_data,
  output logic [3:0]         out_valid,
  input  logic [3:0]         out_ready,
  input  logic               cnt_clr,
  input  logic [1:0]         cnt_sel,
  output logic [7:0]         cnt_val
);

  logic [3:0] full;
  logic [3:0] wr_en;
  logic [3:0] rd_en;
  logic [7:0] cnt_all [4];

  // Ready looks only at registered occupancy, so a same-cycle read never frees a slot.
  assign in_ready = ~full[in_sel];
  assign cnt_val  = cnt_all[cnt_sel];

  for (genvar k = 0; k < 4; k++) begin : g_ch
    logic [WIDTH-1:0] mem [2];
    logic             wr_ptr;
    logic             rd_ptr;
    logic [1:0]       occ;
    logic [7:0]       cnt;

    assign full[k]      = (occ == 2'd2);
    assign out_valid[k] = (occ != 2'd0);
    assign wr_en[k]     = in_valid & in_ready & (in_sel == 2'(k));
    assign rd_en[k]     = out_valid[k] & out_ready[k];
    assign out_data[k*WIDTH +: WIDTH] = mem[rd_ptr];
    assign cnt_all[k]   = cnt;

    always_ff @(posedge clk) begin
      if (wr_en[k]) mem[wr_ptr] <= in_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        wr_ptr <= 1'b0;
        rd_ptr <= 1'b0;
        occ    <= 2'd0;
      end else begin
        if (wr_en[k]) wr_ptr <= ~wr_ptr;
        if (rd_en[k]) rd_ptr <= ~rd_ptr;
        case ({wr_en[k], rd_en[k]})
          2'b10:   occ <= occ + 2'd1;
          2'b01:   occ <= occ - 2'd1;
          default: occ <= occ;
        endcase
      end
    end

    // Clear wins over a same-cycle delivery.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt <= 8'd0;
      end else if (cnt_clr) begin
        cnt <= 8'd0;
      end else if (rd_en[k] && cnt != 8'hFF) begin
        cnt <= cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_demux_router_4.sv
// Bench for demux_router_4: directed vector table, hand sequences for the
// multi-cycle corners, and random traffic against a queue-based model.
module tb_demux_router_4;
  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [W-1:0]   in_data = '0;
  logic [1:0]     in_sel = '0;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [4*W-1:0] out_data;
  logic [3:0]     out_valid;
  logic [3:0]     out_ready = '0;
  logic           cnt_clr = 1'b0;
  logic [1:0]     cnt_sel = '0;
  logic [7:0]     cnt_val;

  demux_router_4 #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_sel(in_sel),
    .in_valid(in_valid), .in_ready(in_ready), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .cnt_clr(cnt_clr),
    .cnt_sel(cnt_sel), .cnt_val(cnt_val)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  logic [7:0] q [4][$];
  int         mcnt [4];

  typedef struct {
    logic       iv;
    logic [1:0] sel;
    logic [7:0] data;
    logic [3:0] ordy;
    logic [1:0] csel;
    logic       e_rdy;
    logic [3:0] e_ov;
    logic [1:0] hch;
    logic [7:0] e_head;
    logic [7:0] e_cnt;
  } vec_t;

  vec_t tbl [18];

  function automatic vec_t mk(logic iv, logic [1:0] sel, logic [7:0] data, logic [3:0] ordy,
                              logic [1:0] csel, logic e_rdy, logic [3:0] e_ov, logic [1:0] hch,
                              logic [7:0] e_head, logic [7:0] e_cnt);
    vec_t v;
    v.iv = iv; v.sel = sel; v.data = data; v.ordy = ordy; v.csel = csel;
    v.e_rdy = e_rdy; v.e_ov = e_ov; v.hch = hch; v.e_head = e_head; v.e_cnt = e_cnt;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic iv, input logic [1:0] sel, input logic [7:0] data,
                       input logic [3:0] ordy, input logic clr, input logic [1:0] csel);
    in_valid = iv; in_sel = sel; in_data = data;
    out_ready = ordy; cnt_clr = clr; cnt_sel = csel;
  endtask

  function automatic logic [7:0] slice(int k);
    logic [4*W-1:0] d;
    d = out_data;
    return d[k*W +: W];
  endfunction

  // One cycle: apply inputs, compare against the model, advance the model over the edge.
  task automatic step(input logic iv, input logic [1:0] sel, input logic [7:0] data,
                      input logic [3:0] ordy, input logic clr, input logic [1:0] csel);
    bit accept;
    drive(iv, sel, data, ordy, clr, csel);
    #1;
    chk("in_ready", in_ready, q[sel].size() < 2);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("out_valid[%0d]", k), out_valid[k], q[k].size() > 0);
      if (q[k].size() > 0) chk($sformatf("head[%0d]", k), slice(k), q[k][0]);
    end
    chk("cnt_val", cnt_val, mcnt[csel]);
    accept = iv && (q[sel].size() < 2);
    for (int k = 0; k < 4; k++) begin
      if (q[k].size() > 0 && ordy[k]) begin
        void'(q[k].pop_front());
        if (mcnt[k] < 255) mcnt[k]++;
      end
      if (clr) mcnt[k] = 0;
    end
    if (accept) q[sel].push_back(data);
    @(posedge clk);
    #1;
  endtask

  task automatic clear_model();
    for (int k = 0; k < 4; k++) begin
      q[k].delete();
      mcnt[k] = 0;
    end
  endtask

  task automatic check_reset_view(input string tag);
    for (int s = 0; s < 4; s++) begin
      drive(1'b0, 2'(s), 8'h00, 4'hF, 1'b0, 2'(s));
      #1;
      chk({tag, " out_valid"}, out_valid, 4'b0000);
      chk({tag, " in_ready"}, in_ready, 1'b1);
      chk({tag, " cnt_val"}, cnt_val, 8'd0);
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    check_reset_view("reset");
    clear_model();
    @(posedge clk);
    #1;
    drive(1'b0, 2'd0, 8'h00, 4'h0, 1'b0, 2'd0);
    rst_n = 1'b1;
  endtask

  initial begin
    tbl[0]  = mk(1, 2, 8'hA5, 4'b0100, 2, 1, 4'b0000, 2, 8'h00, 0);
    tbl[1]  = mk(0, 2, 8'h00, 4'b0100, 2, 1, 4'b0100, 2, 8'hA5, 0);
    tbl[2]  = mk(0, 2, 8'h00, 4'b0000, 2, 1, 4'b0000, 2, 8'h00, 1);
    tbl[3]  = mk(1, 1, 8'h01, 4'b0000, 1, 1, 4'b0000, 1, 8'h00, 0);
    tbl[4]  = mk(1, 1, 8'h02, 4'b0000, 1, 1, 4'b0010, 1, 8'h01, 0);
    tbl[5]  = mk(1, 1, 8'h03, 4'b0000, 1, 0, 4'b0010, 1, 8'h01, 0);
    tbl[6]  = mk(1, 1, 8'h03, 4'b0010, 1, 0, 4'b0010, 1, 8'h01, 0);
    tbl[7]  = mk(1, 1, 8'h03, 4'b0010, 1, 1, 4'b0010, 1, 8'h02, 1);
    tbl[8]  = mk(0, 1, 8'h00, 4'b0010, 1, 1, 4'b0010, 1, 8'h03, 2);
    tbl[9]  = mk(0, 1, 8'h00, 4'b0000, 1, 1, 4'b0000, 1, 8'h00, 3);
    tbl[10] = mk(1, 0, 8'h10, 4'b0000, 0, 1, 4'b0000, 0, 8'h00, 0);
    tbl[11] = mk(1, 0, 8'h11, 4'b0000, 0, 1, 4'b0001, 0, 8'h10, 0);
    tbl[12] = mk(1, 3, 8'h33, 4'b0000, 0, 1, 4'b0001, 0, 8'h10, 0);
    tbl[13] = mk(1, 0, 8'h44, 4'b0000, 0, 0, 4'b1001, 3, 8'h33, 0);
    tbl[14] = mk(0, 0, 8'h00, 4'b0001, 0, 0, 4'b1001, 0, 8'h10, 0);
    tbl[15] = mk(0, 0, 8'h00, 4'b0001, 0, 1, 4'b1001, 0, 8'h11, 1);
    tbl[16] = mk(0, 3, 8'h00, 4'b1000, 0, 1, 4'b1000, 3, 8'h33, 2);
    tbl[17] = mk(0, 0, 8'h00, 4'b0000, 3, 1, 4'b0000, 0, 8'h00, 1);

    clear_model();
    #2;
    check_reset_view("power-on");
    do_reset();

    // Directed vectors: basic route, backpressure/order, channel isolation.
    foreach (tbl[i]) begin
      drive(tbl[i].iv, tbl[i].sel, tbl[i].data, tbl[i].ordy, 1'b0, tbl[i].csel);
      #1;
      chk($sformatf("vec%0d in_ready", i), in_ready, tbl[i].e_rdy);
      chk($sformatf("vec%0d out_valid", i), out_valid, tbl[i].e_ov);
      if (tbl[i].e_ov[tbl[i].hch])
        chk($sformatf("vec%0d head", i), slice(int'(tbl[i].hch)), tbl[i].e_head);
      chk($sformatf("vec%0d cnt_val", i), cnt_val, tbl[i].e_cnt);
      @(posedge clk);
      #1;
    end

    // Simultaneous read and write at occupancy 1.
    do_reset();
    step(1, 2, 8'h50, 4'b0000, 0, 2);
    for (int i = 0; i < 20; i++) begin
      step(1, 2, 8'(8'h60 + i), 4'b0100, 0, 2);
      chk("rw out_valid2", out_valid[2], 1'b1);
      chk("rw head2", slice(2), 8'(8'h60 + i));
    end
    step(0, 2, 8'h00, 4'b0100, 0, 2);
    chk("rw drained", out_valid, 4'b0000);
    chk("rw count", cnt_val, 8'd21);

    // Counter saturation and clear priority.
    do_reset();
    for (int i = 0; i < 310; i++) step(1, 0, 8'(i), 4'b0001, 0, 0);
    chk("cnt saturated", cnt_val, 8'd255);
    step(1, 0, 8'hEE, 4'b0001, 1, 0);
    chk("cnt clr wins", cnt_val, 8'd0);
    step(0, 0, 8'h00, 4'b0001, 0, 0);
    chk("cnt after clr", cnt_val, 8'd1);

    // Reset with two words buffered on every channel.
    do_reset();
    for (int k = 0; k < 4; k++) begin
      step(1, 2'(k), 8'(8'hC0 + k), 4'b0000, 0, 0);
      step(1, 2'(k), 8'(8'hD0 + k), 4'b0000, 0, 0);
    end
    chk("prefill out_valid", out_valid, 4'b1111);
    rst_n = 1'b0;
    check_reset_view("mid reset");
    clear_model();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(0, 2'(i), 8'hFF, 4'b1111, 0, 2'(i));
      chk("no stale words", out_valid, 4'b0000);
    end

    // Random traffic against the queue model.
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      step(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 8'($urandom),
           4'($urandom), ($urandom_range(0, 63) == 0), 2'($urandom_range(0, 3)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
